// File: rtl/lutram_fifo.sv
// lutram_fifo: synchronous FIFO on a DEPTH x WIDTH distributed-RAM array with
// one write port and one asynchronous read port; first-word-fall-through on
// the consumer side, valid/ready handshakes on both ends.
//
// Configuration macro: LUTRAM_FIFO_OUTPUT_REG_EN
//   undefined : out_data/out_valid come straight from the RAM read port,
//               capacity DEPTH, push-to-out_valid latency 1 cycle.
//   defined   : a WIDTH-bit output register plus valid bit follows the RAM,
//               capacity DEPTH+1, push-to-out_valid latency 2 cycles.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all contents
//   in_valid   producer offers in_data
//   in_ready   FIFO can accept (transfer on in_valid & in_ready)
//   in_data    entry to enqueue
//   out_valid  out_data holds the oldest entry
//   out_ready  consumer accepts (transfer on out_valid & out_ready)
//   out_data   oldest entry
//   count      entries held, including the output register when present
module lutram_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+2)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 2);
`ifdef LUTRAM_FIFO_OUTPUT_REG_EN
  localparam int unsigned CAP = DEPTH + 1;
`else
  localparam int unsigned CAP = DEPTH;
`endif
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CAP_C    = CW'(CAP);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_ram_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_rd;
  logic [CW-1:0]    w_count;

  // Compare-based wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // in_ready is held low during reset and while flushing.
  assign in_ready = rst_n & (w_count < CAP_C) & ~flush;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  assign count    = w_count;

`ifdef LUTRAM_FIFO_OUTPUT_REG_EN
  logic             r_ov;
  logic [WIDTH-1:0] r_od;

  // Refill the output register whenever it empties or is being consumed.
  assign w_rd      = (~r_ov | w_pop) & (r_ram_cnt != '0);
  assign w_count   = r_ram_cnt + CW'(r_ov);
  assign out_valid = r_ov & ~flush;
  assign out_data  = r_od;

  // Output register valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov <= 1'b0;
    end else if (flush) begin
      r_ov <= 1'b0;
    end else if (w_rd) begin
      r_ov <= 1'b1;
    end else if (w_pop) begin
      r_ov <= 1'b0;
    end
  end

  // Output register payload; meaningless while r_ov is low.
  always_ff @(posedge clk) begin
    if (w_rd && !flush) begin
      r_od <= r_mem[r_rd_ptr];
    end
  end
`else
  assign w_rd      = w_pop;
  assign w_count   = r_ram_cnt;
  assign out_valid = (r_ram_cnt != '0) & ~flush;
  assign out_data  = r_mem[r_rd_ptr];
`endif

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy tracking for the RAM array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_rd) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_push && !w_rd) begin
        r_ram_cnt <= r_ram_cnt + CW'(1);
      end else if (!w_push && w_rd) begin
        r_ram_cnt <= r_ram_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lutram_fifo.sv
// Bench for lutram_fifo: one DEPTH=4 and one DEPTH=3 instance (WIDTH=8) share
// the same stimulus; a queue-level model per instance predicts every output.
module tb_lutram_fifo;

`ifdef LUTRAM_FIFO_OUTPUT_REG_EN
  localparam int OPT = 1;
`else
  localparam int OPT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [1:0] a_ir;
  logic [1:0] a_ov;
  logic [7:0] a_od  [2];
  logic [2:0] a_cnt [2];

  int checks = 0;
  int errors = 0;

  lutram_fifo #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir[0]), .in_data(in_data),
    .out_valid(a_ov[0]), .out_ready(out_ready), .out_data(a_od[0]),
    .count(a_cnt[0])
  );

  lutram_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_ir[1]), .in_data(in_data),
    .out_valid(a_ov[1]), .out_ready(out_ready), .out_data(a_od[1]),
    .count(a_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every entry ever accepted since the last reset/flush, indexed by
  // monotonically increasing push/pop counts.
  logic [7:0] mbuf [2][256];
  int         n_in  [2];
  int         n_out [2];
  bit         mvis  [2];

  function automatic int m_cnt(input int k);
    return n_in[k] - n_out[k];
  endfunction

  function automatic int m_cap(input int k);
    return ((k == 0) ? 4 : 3) + OPT;
  endfunction

  function automatic bit e_ir(input int k);
    return rst_n && (m_cnt(k) < m_cap(k)) && !flush;
  endfunction

  function automatic bit e_ov(input int k);
    if (OPT == 1) return mvis[k] && !flush;
    return (m_cnt(k) != 0) && !flush;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      n_in[k]  = 0;
      n_out[k] = 0;
      mvis[k]  = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int k = 0; k < 2; k++) begin
        n_in[k]  <= 0;
        n_out[k] <= 0;
        mvis[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid && e_ir(k)) begin
          mbuf[k][n_in[k] % 256] <= in_data;
          n_in[k] <= n_in[k] + 1;
        end
        if (out_ready && e_ov(k)) begin
          n_out[k] <= n_out[k] + 1;
        end
        // Output register (when present) is visible next cycle if it keeps
        // its entry or the RAM behind it holds one.
        mvis[k] <= (mvis[k] && !(out_ready && e_ov(k))) || ((m_cnt(k) - int'(mvis[k])) > 0);
      end
    end
  end

  // Compare process: all outputs every cycle, data only when valid.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), int'(a_ir[k]), int'(e_ir(k)));
      chk($sformatf("out_valid[%0d]", k), int'(a_ov[k]), int'(e_ov(k)));
      chk($sformatf("count[%0d]", k), int'(a_cnt[k]), m_cnt(k));
      if (e_ov(k)) begin
        chk($sformatf("out_data[%0d]", k), int'(a_od[k]), int'(mbuf[k][n_out[k] % 256]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_in_ready", int'(a_ir[0]), 1);
    chk("reset_out_valid", int'(a_ov[0]), 0);
    chk("reset_count", int'(a_cnt[0]), 0);

    // Fill four entries, then drain in order.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'((i + 1) * 8'h11);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", int'(a_cnt[0]), 4);
`ifndef LUTRAM_FIFO_OUTPUT_REG_EN
    chk("fill_in_ready", int'(a_ir[0]), 0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", int'(a_ov[0]), 1);
      chk("drain_data", int'(a_od[0]), (i + 1) * 'h11);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", int'(a_ov[0]), 0);
    step();

    // Push into empty: first-word-fall-through latency.
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
`ifdef LUTRAM_FIFO_OUTPUT_REG_EN
    chk("lat_not_yet", int'(a_ov[0]), 0);
    step();
`endif
    chk("lat_valid", int'(a_ov[0]), 1);
    chk("lat_data", int'(a_od[0]), 'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("lat_drained", int'(a_ov[0]), 0);

    // Streaming push+pop of 0x00..0x0F through both depths.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i); out_ready = 1'b1;
      step();
`ifndef LUTRAM_FIFO_OUTPUT_REG_EN
      chk("stream_count", int'(a_cnt[0]), 1);
      chk("stream_data", int'(a_od[0]), i);
`endif
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    chk("stream_empty", int'(a_cnt[0]), 0);

    // Full: a same-cycle pop does not open a slot for a push.
    for (int i = 0; i < 4 + OPT; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + i);
      step();
    end
    in_data = 8'h5F; out_ready = 1'b1;
    chk("full_in_ready", int'(a_ir[0]), 0);
    chk("full_head", int'(a_od[0]), 'h50);
    step();
    chk("full_after_pop", int'(a_cnt[0]), 3 + OPT);
    chk("full_ready_again", int'(a_ir[0]), 1);
    out_ready = 1'b0;
    step();
    chk("full_refill", int'(a_cnt[0]), 4 + OPT);

    // Drain, load three entries, then flush with both handshakes offered.
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      step();
    end
    chk("preflush_count", int'(a_cnt[0]), 3);
    flush = 1'b1; out_ready = 1'b1; in_data = 8'hEE;
    #1;
    chk("flush_in_ready", int'(a_ir[0]), 0);
    chk("flush_out_valid", int'(a_ov[0]), 0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", int'(a_cnt[0]), 0);
    chk("flush_valid", int'(a_ov[0]), 0);
    step();

    // Reset mid-stream drops everything immediately.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h70 + i);
      step();
    end
    chk("prereset_valid", int'(a_ov[0]), 1);
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_valid", int'(a_ov[0]), 0);
    chk("reset_mid_count", int'(a_cnt[0]), 0);
    chk("reset_mid_ready", int'(a_ir[0]), 0);
    step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    chk("post_reset_ready", int'(a_ir[0]), 1);
    chk("post_reset_valid", int'(a_ov[0]), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lutram_fifo.md
Name: lutram_fifo

Overview:
- Synchronous FIFO built on a DEPTH x WIDTH distributed-RAM array: one write port, one asynchronous read port.
- Adds pointer management, occupancy tracking and valid/ready handshakes on both ends.
- Producer side writes entries; consumer side reads them first-word-fall-through.
- Default queue for decode/issue buffering and load/store queues in the core.

Parameters:
- WIDTH, 32, entry width in bits.
- DEPTH, 4, number of RAM entries; any value >= 2, power of two not required.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all contents.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
- in_data  in  WIDTH  entry to enqueue.
- out_valid  out  1  out_data holds the oldest entry.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- out_data  out  WIDTH  oldest entry.
- count  out  $clog2(DEPTH+2)  entries held (includes output register when the option is enabled).

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, out_valid=0. in_ready=0 while rst_n is low; in_ready=1 on the first cycle after release. RAM contents are not reset; out_data is don't-care while out_valid=0.
- Push: on in_valid & in_ready, RAM[wr_ptr] <= in_data and wr_ptr advances. Wrap is DEPTH-1 -> 0, compare-based, not a power-of-two mask.
- Pop: on out_valid & out_ready, rd_ptr advances with the same wrap rule.
- Count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- in_ready = (count < capacity) & ~flush. Capacity is DEPTH, or DEPTH+1 with the option.
  - Full case: a pop in the same cycle does not allow a push; no bypass when full.
- out_valid = (count != 0) & ~flush. out_data = RAM[rd_ptr], combinational from the array.
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle (1 cycle). The empty-to-nonempty read-after-write path never returns stale data.
- Simultaneous push and pop with 0 < count < DEPTH: both proceed and count is unchanged. When empty, only the push proceeds (out_valid=0).
- Flush: in_ready and out_valid are forced 0 while flush=1, so no handshake completes. On the next edge, pointers=0, count=0 and any output register is invalidated. Flush wins over any push or pop in that cycle.
- Reset mid-operation: immediate return to the reset state; contents are lost.
- Pointers are $clog2(DEPTH) bits wide and never exceed DEPTH-1.

Optional Feature:
- Macro LUTRAM_FIFO_OUTPUT_REG_EN.
- Defined:
  - A WIDTH-bit output register plus valid bit sits after the RAM read port. out_data and out_valid come from this register, with no combinational RAM-to-output path.
  - The register loads RAM[rd_ptr] when it is empty, or is being popped, and the RAM holds entries.
  - Capacity is DEPTH+1. Push-into-empty to out_valid latency is 2 cycles. Full-rate streaming (1 transfer per cycle) is kept.
  - Flush and reset clear the register valid bit.
- Undefined: the behaviour described above.

Test Plan:
- DEPTH=4, WIDTH=8, reset then idle -> in_ready=1, out_valid=0, count=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready=0 -> count=4, in_ready=0; then pop 4 -> data 0x11, 0x22, 0x33, 0x44 in order, out_valid=0 after.
- Push 0xA5 into empty -> out_valid=1 with out_data=0xA5 exactly 1 cycle later (2 with LUTRAM_FIFO_OUTPUT_REG_EN).
- Wrap/stream: continuous push and pop of 0x00..0x0F with out_ready=1 -> output sequence identical, count constant at 1 after fill, pointers wrap 3->0 four times. Repeat with DEPTH=3.
- Full with in_valid=1 and out_ready=1 -> pop completes, push refused that cycle (in_ready=0), count 4->3; the push is accepted the next cycle.
- Flush with count=3 while in_valid=1 and out_ready=1 -> no transfers that cycle, count=0 next cycle, out_valid=0. Assert rst_n=0 mid-stream -> out_valid drops immediately.
